// File: rtl/gps_iq_capture.sv
// Epoch-triggered IQ snapshot collector: clocks six 16-bit correlator sums out of the
// demodulator, stamps each snapshot with an epoch count and queues it in a 2-entry FIFO.
module gps_iq_capture (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        epoch,
  input  logic        sin,
  output logic        shift,
  input  logic [2:0]  rd_sel,
  output logic [15:0] rd_data,
  input  logic        ack,
  input  logic        clr,
  output logic        valid,
  output logic        ovf,
  output logic        coll
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [6:0]   bc_reg, bc_next;
  logic [94:0]  sr_reg;
  logic [15:0]  ep_cnt_reg;
  logic [15:0]  stamp_reg;
  logic         push;
  logic         coll_set;
  logic         ep_hit;
  logic [95:0]  iq_word;

  assign ep_hit  = epoch & en;
  // The last serial bit is taken straight from sin so the word is complete in the push cycle.
  assign iq_word = {sr_reg, sin};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      bc_reg    <= 7'd0;
    end else begin
      state_reg <= state_next;
      bc_reg    <= bc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bc_next    = bc_reg;
    push       = 1'b0;
    coll_set   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ep_hit) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (epoch) begin
          coll_set   = 1'b1;
          state_next = ST_LOAD;
        end else begin
          state_next = ST_SHIFT;
          bc_next    = 7'd0;
        end
      end
      ST_SHIFT: begin
        // A collision on the final bit still discards the word; the restart wins.
        if (!en) begin
          state_next = ST_IDLE;
        end else if (epoch) begin
          coll_set   = 1'b1;
          state_next = ST_LOAD;
        end else begin
          bc_next = bc_reg + 7'd1;
          if (bc_reg == 7'd95) begin
            push       = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign shift = (state_reg == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg <= '0;
    end else if (state_reg == ST_SHIFT) begin
      sr_reg <= {sr_reg[93:0], sin};
    end
  end

  // Every accepted epoch (re)starts a capture, so the stamp is refreshed on each one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ep_cnt_reg <= 16'd0;
      stamp_reg  <= 16'd0;
    end else if (ep_hit) begin
      ep_cnt_reg <= ep_cnt_reg + 16'd1;
      stamp_reg  <= ep_cnt_reg + 16'd1;
    end
  end

  logic [111:0] entry_reg [2];
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         pop;
  logic         accept;
  logic         wr_idx;
  logic         ovf_set;
  logic [111:0] head;

  assign pop     = ack && (count_reg != 2'd0);
  assign accept  = push && ((count_reg != 2'd2) || ack);
  assign ovf_set = push && (count_reg == 2'd2) && !ack;
  // When full with a pop, rd_ptr + 2 wraps onto the slot being vacated.
  assign wr_idx  = rd_ptr_reg ^ count_reg[0];

  always_ff @(posedge clk) begin
    if (accept) entry_reg[wr_idx] <= {iq_word, stamp_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      rd_ptr_reg <= rd_ptr_reg ^ pop;
      count_reg  <= count_reg + {1'b0, accept} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf  <= 1'b0;
      coll <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (clr)     ovf <= 1'b0;
      if (coll_set)     coll <= 1'b1;
      else if (clr)     coll <= 1'b0;
    end
  end

  assign valid = (count_reg != 2'd0);
  assign head  = entry_reg[rd_ptr_reg];

  logic [15:0] field [8];

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_field
      assign field[gi] = head[111 - 16*gi -: 16];
    end
  endgenerate

  assign field[7] = {12'd0, ovf, coll, count_reg};

  always_comb begin
    rd_data = 16'd0;
    if (rd_sel == 3'd7 || count_reg != 2'd0) rd_data = field[rd_sel];
  end

endmodule

// File: tb/tb_gps_iq_capture.sv
// Directed bench for gps_iq_capture with a serial model of the demodulator's shift register.
module tb_gps_iq_capture;

  logic        clk = 1'b0;
  logic        rst, en, epoch, sin, shift, ack, clr, valid, ovf, coll;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [95:0] tx_reg  = '0;
  logic [95:0] pat     = '0;
  logic        ld_pend = 1'b0;

  localparam logic [95:0] PAT_A = 96'h1234_5678_9ABC_DEF0_0F0F_F0F0;
  localparam logic [95:0] PAT_B = 96'hAAAA_5555_0001_8000_FFFF_0000;
  localparam logic [95:0] PAT_C = 96'h1111_2222_3333_4444_5555_6666;

  always #10 clk = ~clk;

  gps_iq_capture dut (
    .clk(clk), .rst(rst), .en(en), .epoch(epoch), .sin(sin), .shift(shift),
    .rd_sel(rd_sel), .rd_data(rd_data), .ack(ack), .clr(clr),
    .valid(valid), .ovf(ovf), .coll(coll)
  );

  // Demodulator loads its register the cycle after ms0 and shifts MSB first on each strobe.
  always @(posedge clk) begin
    ld_pend <= epoch & en & ~rst;
    if (ld_pend)    tx_reg <= pat;
    else if (shift) tx_reg <= {tx_reg[94:0], 1'b0};
  end
  assign sin = tx_reg[95];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] sel, input logic [15:0] exp);
    rd_sel = sel;
    #1;
    check(tag, {16'd0, rd_data}, {16'd0, exp});
  endtask

  task automatic check_entry(input string tag, input logic [95:0] p, input logic [15:0] st);
    logic [95:0] v;
    v = p;
    for (int i = 0; i < 6; i++) begin
      rd_chk($sformatf("%s_f%0d", tag, i), 3'(i), v[95 - 16*i -: 16]);
    end
    rd_chk({tag, "_stamp"}, 3'd6, st);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; epoch = 1'b0; ack = 1'b0; clr = 1'b0; rd_sel = 3'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Pulses epoch, then counts shift-high cycles; returns valid as seen in the last shift cycle.
  task automatic capture(input logic [95:0] p, input bit ack_end, output int nshift,
                         output logic last_valid);
    pat = p;
    epoch = 1'b1;
    step();
    epoch = 1'b0;
    check("load_shift_low", {31'd0, shift}, 32'd0);
    nshift = 0;
    last_valid = 1'b0;
    step();
    for (int i = 0; i < 200 && shift; i++) begin
      nshift++;
      last_valid = valid;
      if (ack_end && nshift == 96) ack = 1'b1;
      step();
      ack = 1'b0;
    end
    check("shift_len", nshift, 32'd96);
    $display("capture: %0d shift cycles, valid=%0b", nshift, valid);
  endtask

  int   ns;
  logic lv;

  initial begin
    // Reset state
    do_reset();
    check("rst_shift", {31'd0, shift}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ovf",   {31'd0, ovf},   32'd0);
    check("rst_coll",  {31'd0, coll},  32'd0);
    for (int s = 0; s < 8; s++) rd_chk($sformatf("rst_rd%0d", s), 3'(s), 16'h0000);

    // 1: basic capture
    capture(PAT_A, 1'b0, ns, lv);
    check("t1_valid_prev", {31'd0, lv}, 32'd0);
    check("t1_valid", {31'd0, valid}, 32'd1);
    check_entry("t1", PAT_A, 16'h0001);
    rd_chk("t1_status", 3'd7, 16'h0001);

    // 2: overflow
    do_reset();
    capture(PAT_A, 1'b0, ns, lv);
    capture(PAT_B, 1'b0, ns, lv);
    capture(PAT_C, 1'b0, ns, lv);
    rd_chk("t2_status", 3'd7, 16'h000A);
    check_entry("t2_head", PAT_A, 16'h0001);
    ack = 1'b1; step(); ack = 1'b0;
    check_entry("t2_next", PAT_B, 16'h0002);
    ack = 1'b1; step(); ack = 1'b0;
    check("t2_valid", {31'd0, valid}, 32'd0);
    rd_chk("t2_status_empty", 3'd7, 16'h0008);
    rd_chk("t2_empty_rd0", 3'd0, 16'h0000);
    clr = 1'b1; step(); clr = 1'b0;
    rd_chk("t2_status_clr", 3'd7, 16'h0000);

    // 3: simultaneous push and ack while full
    do_reset();
    capture(PAT_A, 1'b0, ns, lv);
    capture(PAT_B, 1'b0, ns, lv);
    capture(PAT_C, 1'b1, ns, lv);
    rd_chk("t3_status", 3'd7, 16'h0002);
    rd_chk("t3_head_stamp", 3'd6, 16'h0002);
    ack = 1'b1; step(); ack = 1'b0;
    check_entry("t3_next", PAT_C, 16'h0003);

    // 4: collision 40 cycles into SHIFT
    do_reset();
    pat = PAT_A;
    epoch = 1'b1; step(); epoch = 1'b0;
    repeat (41) step();
    check("t4_in_shift", {31'd0, shift}, 32'd1);
    capture(PAT_B, 1'b0, ns, lv);
    check("t4_coll", {31'd0, coll}, 32'd1);
    rd_chk("t4_status", 3'd7, 16'h0005);
    check_entry("t4", PAT_B, 16'h0002);

    // 5: reset mid-SHIFT, then enable drop mid-SHIFT
    do_reset();
    capture(PAT_A, 1'b0, ns, lv);
    pat = PAT_B;
    epoch = 1'b1; step(); epoch = 1'b0;
    repeat (21) step();
    rst = 1'b1; step();
    check("t5_rst_shift", {31'd0, shift}, 32'd0);
    check("t5_rst_valid", {31'd0, valid}, 32'd0);
    rd_chk("t5_rst_status", 3'd7, 16'h0000);
    rd_chk("t5_rst_rd0", 3'd0, 16'h0000);
    rst = 1'b0;
    capture(PAT_C, 1'b0, ns, lv);
    check_entry("t5_after_rst", PAT_C, 16'h0001);
    pat = PAT_A;
    epoch = 1'b1; step(); epoch = 1'b0;
    repeat (21) step();
    en = 1'b0; step();
    check("t5_en_shift", {31'd0, shift}, 32'd0);
    repeat (100) step();
    en = 1'b1;
    rd_chk("t5_en_status", 3'd7, 16'h0001);
    rd_chk("t5_en_stamp", 3'd6, 16'h0001);
    capture(PAT_B, 1'b0, ns, lv);
    ack = 1'b1; step(); ack = 1'b0;
    check_entry("t5_post_en", PAT_B, 16'h0003);

    // 6: counter wrap via back-to-back epochs (each counts, each collides)
    do_reset();
    pat = PAT_C;
    epoch = 1'b1;
    repeat (65534) step();
    epoch = 1'b0; en = 1'b0; step();
    en = 1'b1; step();
    check("t6_idle_valid", {31'd0, valid}, 32'd0);
    capture(PAT_A, 1'b0, ns, lv);
    check_entry("t6_ffff", PAT_A, 16'hFFFF);
    rd_chk("t6_status", 3'd7, 16'h0005);
    ack = 1'b1; clr = 1'b1; step(); ack = 1'b0; clr = 1'b0;
    capture(PAT_B, 1'b0, ns, lv);
    check_entry("t6_wrap", PAT_B, 16'h0000);
    rd_chk("t6_status2", 3'd7, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
